// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB-first, stop bit,
// each bit held for CLKS_PER_BIT clocks. Accepts one word per valid/ready handshake.
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = $clog2(DATA_W + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_nx;
  logic [BAUD_W-1:0]   baud, baud_nx;
  logic [IDX_W-1:0]    idx, idx_nx;
  logic [DATA_W-1:0]   shreg, shreg_nx;
  logic                done_nx;
  logic                bit_end;

  assign bit_end = (baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      baud  <= '0;
      idx   <= '0;
      shreg <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      baud  <= baud_nx;
      idx   <= idx_nx;
      shreg <= shreg_nx;
      done  <= done_nx;
    end
  end

  // With CLKS_PER_BIT=1 bit_end is always true, so the baud increment is never taken.
  always_comb begin
    state_nx = state;
    baud_nx  = baud;
    idx_nx   = idx;
    shreg_nx = shreg;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        baud_nx = '0;
        idx_nx  = '0;
        if (tx_valid) begin
          shreg_nx = tx_data;
          state_nx = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_nx  = '0;
          idx_nx   = '0;
          state_nx = DATA;
        end else begin
          baud_nx = baud + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nx  = '0;
          shreg_nx = shreg >> 1;
          if (idx == IDX_LAST) begin
            state_nx = STOP;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end else begin
          baud_nx = baud + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_nx  = '0;
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          baud_nx = baud + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line level is decoded from state and the shift register only, so reset
  // forces it high immediately and tx_valid never reaches it combinationally.
  always_comb begin
    tx_out = 1'b1;
    unique case (state)
      START:   tx_out = 1'b0;
      DATA:    tx_out = shreg[0];
      default: tx_out = 1'b1;
    endcase
  end

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule
